// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and constants for the multicycle control unit
// Contents: state_t encoding, opcode values, mux select constants, control word layout.
package mc_ctrl_pkg;

    localparam int OPW_DEF = 6;
    localparam int STW_DEF = 4;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - per-state control word decoder
// Ports: state_i (current state), mem_ready_i (memory handshake), ctrl_o (packed ctrl_t).
module mc_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0]        state_i,
    input  logic              mem_ready_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    ctrl_t cw;

    always_comb begin
        cw = '0;
        case (state_t'(state_i))
            S_FETCH: begin
                cw.alusrcb = SRCB_FOUR;
                // IR and PC only advance once the instruction fetch completes
                cw.irwrite = mem_ready_i;
                cw.pcwrite = mem_ready_i;
            end
            S_DECODE: begin
                cw.alusrcb = SRCB_IMMSH;
            end
            S_MEMADR: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                cw.iord = 1'b1;
            end
            S_MEMWB: begin
                cw.memtoreg = 1'b1;
                cw.regwrite = 1'b1;
            end
            S_MEMWR: begin
                // write stays asserted through every wait cycle of the store
                cw.iord     = 1'b1;
                cw.memwrite = 1'b1;
            end
            S_EXEC: begin
                cw.alusrca = 1'b1;
                cw.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw.regdst   = 1'b1;
                cw.regwrite = 1'b1;
            end
            S_BEQ: begin
                cw.alusrca = 1'b1;
                cw.aluop   = ALUOP_SUB;
                cw.pcsrc   = PCSRC_ALUOUT;
                cw.branch  = 1'b1;
            end
            S_ADDIEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
            end
            S_ADDIWB: begin
                cw.regwrite = 1'b1;
            end
            S_JMP: begin
                cw.pcsrc   = PCSRC_JUMP;
                cw.pcwrite = 1'b1;
            end
            default: begin
                cw = '0;
            end
        endcase
    end

    assign ctrl_o = cw;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM
// Inputs: clk, reset (sync, active-high), op, zero, mem_ready.
// Outputs: datapath mux selects and write enables, pcen, illegal_op pulse, debug state.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           iord,
    output logic           memwrite,
    output logic           irwrite,
    output logic           regdst,
    output logic           memtoreg,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     pcsrc,
    output logic [1:0]     aluop,
    output logic           pcen,
    output logic           illegal_op,
    output logic [STW-1:0] state
);

    state_t            state_q;
    state_t            state_d;
    logic [CTRL_W-1:0] ctrl_bits;
    ctrl_t             cw;
    logic [5:0]        op6;

    assign op6 = 6'(op);

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op6)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op6 == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op6 == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // output decode
    mc_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_bits)
    );

    assign cw = ctrl_t'(ctrl_bits);

    // Write-type enables are squashed during reset so an aborted instruction
    // cannot leave a partial write behind.
    always_comb begin
        iord       = cw.iord;
        memwrite   = cw.memwrite & ~reset;
        irwrite    = cw.irwrite & ~reset;
        regdst     = cw.regdst;
        memtoreg   = cw.memtoreg;
        regwrite   = cw.regwrite & ~reset;
        alusrca    = cw.alusrca;
        alusrcb    = cw.alusrcb;
        pcsrc      = cw.pcsrc;
        aluop      = cw.aluop;
        pcen       = (cw.pcwrite | (cw.branch & zero)) & ~reset;
        illegal_op = (state_q == S_DECODE) & ~op_is_legal(op6) & ~reset;
        state      = STW'(state_q);
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       pcen, illegal_op;
    logic [3:0] state;

    int vectors;
    int miscompares;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;

    multicycle_ctrl #(.OPW(6), .STW(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen),
        .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] got_vec();
        return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, aluop, pcen, illegal_op};
    endfunction

    function automatic bit known_op(input logic [5:0] o);
        return o inside {LW, SW, RT, BQ, AI, JJ};
    endfunction

    // Expected outputs straight from the per-state output table.
    function automatic logic [14:0] exp_vec(input int s, input bit mr, input bit z,
                                            input logic [5:0] o, input bit rst);
        logic e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_asa, e_pcen, e_ill;
        logic [1:0] e_asb, e_pcs, e_aop;
        {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_asa, e_pcen, e_ill} = '0;
        e_asb = 2'b00; e_pcs = 2'b00; e_aop = 2'b00;
        case (s)
            0:  begin e_asb = 2'b01; e_ir = mr; e_pcen = mr; end
            1:  begin e_asb = 2'b11; e_ill = !known_op(o); end
            2:  begin e_asa = 1; e_asb = 2'b10; end
            3:  e_iord = 1;
            4:  begin e_m2r = 1; e_rw = 1; end
            5:  begin e_iord = 1; e_mw = 1; end
            6:  begin e_asa = 1; e_aop = 2'b10; end
            7:  begin e_rd = 1; e_rw = 1; end
            8:  begin e_asa = 1; e_aop = 2'b01; e_pcs = 2'b01; e_pcen = z; end
            9:  begin e_asa = 1; e_asb = 2'b10; end
            10: e_rw = 1;
            11: begin e_pcs = 2'b10; e_pcen = 1; end
            default: ;
        endcase
        if (rst) begin
            e_mw = 0; e_ir = 0; e_rw = 0; e_pcen = 0; e_ill = 0;
        end
        return {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_asa, e_asb, e_pcs, e_aop, e_pcen, e_ill};
    endfunction

    // Runs one instruction: builds the expected state walk from the opcode and the
    // chosen wait counts, then drives/checks it cycle by cycle. abort_at >= 0 asserts
    // reset in that cycle and ends the instruction there. zmode: 0/1 forced, else random.
    task automatic apply_instr(input logic [5:0] opv, input int fwait, input int mwait,
                               input int abort_at, input int zmode, input string tag);
        int st_q[$];
        bit mr_q[$];
        logic [14:0] exp;
        logic [14:0] got;
        bit rst;
        for (int k = 0; k < fwait; k++) begin st_q.push_back(0); mr_q.push_back(0); end
        st_q.push_back(0); mr_q.push_back(1);
        st_q.push_back(1); mr_q.push_back(1'($urandom));
        case (opv)
            LW: begin
                st_q.push_back(2); mr_q.push_back(1'($urandom));
                for (int k = 0; k < mwait; k++) begin st_q.push_back(3); mr_q.push_back(0); end
                st_q.push_back(3); mr_q.push_back(1);
                st_q.push_back(4); mr_q.push_back(1'($urandom));
            end
            SW: begin
                st_q.push_back(2); mr_q.push_back(1'($urandom));
                for (int k = 0; k < mwait; k++) begin st_q.push_back(5); mr_q.push_back(0); end
                st_q.push_back(5); mr_q.push_back(1);
            end
            RT: begin st_q.push_back(6); st_q.push_back(7); mr_q.push_back(1'($urandom)); mr_q.push_back(1'($urandom)); end
            BQ: begin st_q.push_back(8); mr_q.push_back(1'($urandom)); end
            AI: begin st_q.push_back(9); st_q.push_back(10); mr_q.push_back(1'($urandom)); mr_q.push_back(1'($urandom)); end
            JJ: begin st_q.push_back(11); mr_q.push_back(1'($urandom)); end
            default: ;
        endcase
        for (int i = 0; i < st_q.size(); i++) begin
            @(negedge clk);
            rst = (i == abort_at);
            reset = rst;
            mem_ready = mr_q[i];
            zero = (zmode == 0) ? 1'b0 : (zmode == 1) ? 1'b1 : 1'($urandom);
            op = (st_q[i] == 1 || st_q[i] == 2) ? opv : 6'($urandom);
            #1;
            exp = exp_vec(st_q[i], mem_ready, zero, opv, rst);
            got = got_vec();
            vectors++;
            if (state !== 4'(st_q[i])) begin
                miscompares++;
                $display("FAIL %s state cyc=%0d: got %0d expected %0d", tag, i, state, st_q[i]);
            end
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s outputs cyc=%0d st=%0d: got %b expected %b", tag, i, st_q[i], got, exp);
            end
            if (rst) break;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1; mem_ready = 1; zero = 1; op = 6'h3f;
            #1;
            vectors++;
            if (state !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_state: got %0d expected 0", state);
            end
            vectors++;
            if ({irwrite, pcen, regwrite, memwrite, illegal_op} !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_enables: got %b expected 00000",
                         {irwrite, pcen, regwrite, memwrite, illegal_op});
            end
        end
    endtask

    task automatic test_lw();         apply_instr(LW, 0, 0, -1, 2, "lw"); endtask
    task automatic test_sw_wait();    apply_instr(SW, 0, 2, -1, 2, "sw_wait"); endtask
    task automatic test_beq();
        apply_instr(BQ, 0, 0, -1, 1, "beq_taken");
        apply_instr(BQ, 0, 0, -1, 0, "beq_not_taken");
    endtask
    task automatic test_rtype_j();
        apply_instr(RT, 0, 0, -1, 2, "rtype");
        apply_instr(JJ, 0, 0, -1, 2, "jump");
        apply_instr(AI, 0, 0, -1, 2, "addi");
    endtask
    task automatic test_fetch_wait(); apply_instr(RT, 3, 0, -1, 2, "fetch_wait"); endtask
    task automatic test_illegal();    apply_instr(6'b111111, 0, 0, -1, 2, "illegal"); endtask
    task automatic test_reset_midinstr();
        apply_instr(LW, 0, 2, 4, 2, "rst_memrd");
        apply_instr(SW, 0, 3, 4, 2, "rst_memwr");
        apply_instr(LW, 1, 1, -1, 2, "after_rst");
    endtask
    task automatic test_back_to_back();
        logic [5:0] opv;
        logic [5:0] ops[6];
        ops = '{LW, SW, RT, BQ, AI, JJ};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) opv = 6'($urandom);
            else opv = ops[$urandom_range(0, 5)];
            apply_instr(opv, $urandom_range(0, 2), $urandom_range(0, 2),
                        ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1,
                        2, "random");
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1; op = 0; zero = 0; mem_ready = 0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_rtype_j();
        test_fetch_wait();
        test_illegal();
        test_reset_midinstr();
        test_back_to_back();
        @(negedge clk);
        reset = 0; mem_ready = 0;
        #1;
        vectors++;
        if (state !== 4'd0) begin
            miscompares++;
            $display("FAIL final_state: got %0d expected 0", state);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control unit for the MIPS-subset core. It sequences a shared-memory, single-ALU datapath over 3-5 cycles per instruction, replacing the single-cycle main decoder path. Opcodes are decoded from the instruction register, and per-state control words drive the datapath muxes and write enables. Memory accesses use a ready handshake, so slow instruction and data memory is tolerated.

Parameters:
OPW, 6, opcode width
STW, 4, state register width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; state register forced to FETCH on the clk edge where reset=1
op  in  6  opcode field, instr[31:26], taken from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  data memory write enable
irwrite  out  1  instruction register load enable
regdst  out  1  register write address select: 1=rd, 0=rt
memtoreg  out  1  register write data select: 1=Data, 0=ALUOut
regwrite  out  1  register file write enable
alusrca  out  1  ALU A select: 0=PC, 1=A
alusrcb  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
aluop  out  2  to aludec: 00=add, 01=sub, 10=funct
pcen  out  1  PC load enable
illegal_op  out  1  one-cycle pulse when DECODE sees an unknown opcode
state  out  4  current state, for debug and verification

Behaviour:
- Moore FSM; all outputs are decoded from the registered state, plus zero and mem_ready where noted.
- Any output not listed for a state is 0.
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JMP=11
- Per-state outputs:
  - FETCH: alusrcb=01; irwrite=mem_ready; pcwrite=mem_ready.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1, held for every cycle of the state.
  - EXEC: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BEQ: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JMP: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero). This is the only combinational dependence on zero.
- Transitions:
  - FETCH -> DECODE when mem_ready=1; otherwise stay in FETCH.
  - DECODE -> by opcode:
    - 100011 (LW) and 101011 (SW) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (BEQ) -> BEQ
    - 001000 (ADDI) -> ADDIEX
    - 000010 (J) -> JMP
    - any other opcode -> FETCH, with illegal_op=1 in that DECODE cycle
  - MEMADR -> MEMRD if op=LW, MEMWR if op=SW.
  - MEMRD -> MEMWB when mem_ready=1, else stay.
  - MEMWR -> FETCH when mem_ready=1, else stay.
  - EXEC -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BEQ, JMP -> FETCH.
- Latency with mem_ready tied high:
  - LW 5 cycles; SW, R-type, ADDI 4 cycles; BEQ, J 3 cycles.
  - Each wait cycle adds exactly one cycle.
- Reset:
  - While reset=1, irwrite, pcen, regwrite, memwrite and illegal_op are forced to 0, regardless of state.
  - Reset asserted mid-instruction (including during a MEMWR wait) aborts the instruction; the next state is FETCH, and no partial write is issued after the reset edge.
  - Unused encodings 12-15 -> FETCH on the next edge, all enables 0.
- op is sampled only in DECODE and MEMADR. The datapath holds the IR stable; op changes in other states are ignored.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum (4-bit, encodings above)
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - aluop constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alusrcb and pcsrc select constants
- One combinational sub-module, mc_outdec, maps state_t to the control word. The top level holds the state register, next-state logic, and the pcen/illegal_op glue.

Test Plan:
- LW with mem_ready=1 throughout: states 0,1,2,3,4; regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3; total 5 cycles.
- SW with mem_ready low for 2 cycles in MEMWR: memwrite=1 for 3 consecutive cycles, then FETCH; regwrite never asserted.
- BEQ with zero=1: pcen=1 in the BEQ state. Repeat with zero=0: pcen=0. Both return to FETCH after 3 cycles.
- R-type (op=000000) then J (op=000010): aluop=10 in EXEC, regdst=1 and regwrite=1 in ALUWB; pcsrc=10 and pcen=1 in JMP.
- FETCH with mem_ready=0 for 3 cycles: irwrite=0, pcen=0, state stays 0; both rise in the cycle mem_ready=1.
- op=111111 in DECODE: illegal_op pulses for 1 cycle, next state FETCH. Then reset=1 during MEMRD: next state FETCH, with no regwrite at any point.
